seven_seg_scanner: RTL
======================

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter N_DISP, default 2, number of independent display channels.
REQ-002 Parameter N_DIGITS, default 4, digits per channel, range 1..8.
REQ-003 Parameter SCAN_DIV, default 131072, clk cycles per digit slot, minimum 16.
REQ-004 Parameter BLINK_FRAMES, default 32, frames per blink half-period.
REQ-005 clk  in  1  single system clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 load  in  1  one-cycle strobe; captures value, dp and lz_blank into the pending buffer.
REQ-008 value  in  N_DISP*N_DIGITS*4  hex nibbles; channel c digit i at bits [(c*N_DIGITS+i)*4 +: 4].
REQ-009 dp  in  N_DISP*N_DIGITS  decimal-point enables, same indexing.
REQ-010 lz_blank  in  N_DISP  per-channel leading-zero blanking enable.
REQ-011 blink  in  N_DISP  per-channel blink enable, sampled live.
REQ-012 bright  in  4  brightness, 0 = 1/16 duty, 15 = full duty.
REQ-013 an  out  N_DISP*N_DIGITS  active-low anodes; channel c digit i at bit c*N_DIGITS+i.
REQ-014 seg  out  N_DISP*8  active-low segments; channel c at [c*8 +: 8], bit 7 = DP, bits 6:0 = g..a.
REQ-015 frame_done  out  1  one-cycle pulse when the scan wraps from digit N_DIGITS-1 to digit 0.

Function
REQ-016 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; digit index SHALL advance (mod N_DIGITS) on each prescaler wrap.
REQ-017 All channels SHALL scan the same digit index simultaneously; exactly one anode per channel SHALL be low while lit.
REQ-018 The load strobe SHALL write the pending buffer and set a pending flag; the display register SHALL NOT change on load.
REQ-019 On the frame-boundary cycle with the pending flag set, the display register SHALL take the pending buffer and clear the flag.
REQ-020 If load and a frame boundary coincide, the display register SHALL take the live inputs directly and the pending flag SHALL end clear.
REQ-021 Decode SHALL be hex 0-F -> C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E, with bit 7 cleared when the digit's dp bit is set.
REQ-022 With lz_blank[c]=1, digit i>0 SHALL be blanked when it and all higher digits are 0; digit 0 is never blanked.
REQ-023 A blanked digit SHALL drive seg 8'hFF, or 8'h7F when its dp is set; its anode SHALL stay active.
REQ-024 A digit SHALL be lit while prescaler*16 < (bright+1)*SCAN_DIV; otherwise its anodes SHALL be all high. bright SHALL be sampled at slot start.
REQ-025 Blink phase SHALL toggle every BLINK_FRAMES frame_done pulses. In the off phase, channels with blink[c]=1 SHALL drive all anodes high.
REQ-026 an, seg and frame_done SHALL be registered, with exactly one cycle latency from the prescaler/digit state.
REQ-027 The scan SHALL free-run; there is no stall or enable input.

Reset
REQ-028 rst SHALL clear prescaler, digit index, blink counter, display register, pending buffer and pending flag, and SHALL set blink phase to on.
REQ-029 During and after rst: an all 1s, seg all 8'hFF, frame_done 0; scanning SHALL resume from digit 0 on the first cycle after rst deasserts.
REQ-030 rst asserted mid-frame SHALL discard any pending load.

Structure
REQ-031 Shared package seven_seg_pkg SHALL hold the hex-to-segment decode function, SEG_BLANK = 8'hFF and SEG_DP_BIT = 7.
REQ-032 One sub-module, seven_seg_decode (nibble + dp + blank -> 8-bit seg), SHALL be instantiated once per channel.

Verification (SCAN_DIV=16, N_DIGITS=4, N_DISP=2, BLINK_FRAMES=2)
REQ-033 rst, then no load -> seg=C0 on both channels; an cycles 1110,1101,1011,0111 every 16 cycles; frame_done every 64 cycles.
REQ-034 load value ch0=0x00A5 with lz_blank[0]=1 mid-frame -> ch0 unchanged until the next frame_done, then shows 92,88,FF,FF.
REQ-035 load issued on the frame_done cycle with ch1=0x1234 -> digits 4,3,2,1 (99,B0,A4,F9) in that same frame; pending flag clear.
REQ-036 bright=3 -> each anode low for 4 of 16 cycles per slot; bright=15 -> low for all 16.
REQ-037 blink=2'b10 -> ch1 anodes all high for 2 frames, then lit for 2 frames; ch0 always lit.
REQ-038 rst asserted for 1 cycle mid-slot after a pending load -> outputs blank for that cycle, restart at digit 0 showing 0, pending load discarded.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants and hex-to-segment decode for the seven-segment scanner.
package seven_seg_pkg;

    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam int         SEG_DP_BIT = 7;

    typedef enum logic {
        BLINK_OFF = 1'b0,
        BLINK_ON  = 1'b1
    } blink_phase_e;

    // Active-low pattern, bit 7 (DP) left high.
    function automatic logic [7:0] hex2seg(input logic [3:0] nib);
        logic [7:0] s;
        unique case (nib)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            4'hF: s = 8'h8E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// One digit of segment decode: nibble, decimal point and blank flag to
// the active-low segment byte.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       dp_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = blank_i ? SEG_BLANK : hex2seg(nib_i);
        if (dp_i) begin
            seg_o[SEG_DP_BIT] = 1'b0;
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed multi-channel seven-segment scanner with frame-synchronous
// display update, leading-zero blanking, PWM brightness and blink.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int N_DISP       = 2,
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 131072,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic [N_DISP*N_DIGITS*4-1:0] value,
    input  logic [N_DISP*N_DIGITS-1:0]   dp,
    input  logic [N_DISP-1:0]            lz_blank,
    input  logic [N_DISP-1:0]            blink,
    input  logic [3:0]                   bright,
    output logic [N_DISP*N_DIGITS-1:0]   an,
    output logic [N_DISP*8-1:0]          seg,
    output logic                         frame_done
);

    localparam int NB = N_DISP * N_DIGITS;
    localparam int PW = $clog2(SCAN_DIV);
    localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int CW = PW + 5;

    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DIG_MAX   = DW'(N_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

    logic [PW-1:0]     presc_q, presc_d;
    logic [DW-1:0]     dig_q, dig_d;
    logic [3:0]        bright_q, bright_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    blink_phase_e      bph_q, bph_d;

    logic [NB*4-1:0]   disp_val_q, disp_val_d;
    logic [NB-1:0]     disp_dp_q, disp_dp_d;
    logic [N_DISP-1:0] disp_lz_q, disp_lz_d;
    logic [NB*4-1:0]   pend_val_q, pend_val_d;
    logic [NB-1:0]     pend_dp_q, pend_dp_d;
    logic [N_DISP-1:0] pend_lz_q, pend_lz_d;
    logic              pend_q, pend_d;

    logic [NB-1:0]       an_q, an_d;
    logic [N_DISP*8-1:0] seg_q, seg_d;
    logic                fd_q, fd_d;

    logic              slot_end;
    logic              lit;
    logic [CW-1:0]     lit_lhs, lit_rhs;
    logic [N_DISP-1:0] ch_on;

    assign slot_end = (presc_q == PRESC_MAX);

    // Scan position, blink phase and buffer bookkeeping.
    always_comb begin
        presc_d = slot_end ? '0 : presc_q + 1'b1;
        dig_d   = dig_q;
        if (slot_end) begin
            dig_d = (dig_q == DIG_MAX) ? '0 : dig_q + 1'b1;
        end
        fd_d     = slot_end && (dig_q == DIG_MAX);
        bright_d = (presc_q == '0) ? bright : bright_q;

        bcnt_d = bcnt_q;
        bph_d  = bph_q;
        if (fd_q) begin
            if (bcnt_q == BLINK_MAX) begin
                bcnt_d = '0;
                bph_d  = (bph_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end

        pend_val_d = load ? value    : pend_val_q;
        pend_dp_d  = load ? dp       : pend_dp_q;
        pend_lz_d  = load ? lz_blank : pend_lz_q;
        pend_d     = pend_q;
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        disp_lz_d  = disp_lz_q;

        // fd_q marks the first cycle of a new frame; updating here lets
        // digit 0 of that frame already show the new contents.
        if (fd_q && load) begin
            disp_val_d = value;
            disp_dp_d  = dp;
            disp_lz_d  = lz_blank;
            pend_d     = 1'b0;
        end else if (fd_q && pend_q) begin
            disp_val_d = pend_val_q;
            disp_dp_d  = pend_dp_q;
            disp_lz_d  = pend_lz_q;
            pend_d     = 1'b0;
        end else if (load) begin
            pend_d = 1'b1;
        end
    end

    assign lit_lhs = CW'({presc_q, 4'b0000});
    assign lit_rhs = CW'({1'b0, bright_d} + 5'd1) * CW'(SCAN_DIV);
    assign lit     = (lit_lhs < lit_rhs);

    for (genvar c = 0; c < N_DISP; c++) begin : g_ch
        logic [N_DIGITS-1:0] zero_hi;
        logic [3:0]          nib;
        logic                dpb;
        logic                blank;

        always_comb begin
            logic z;
            zero_hi = '0;
            z       = 1'b1;
            for (int i = N_DIGITS - 1; i >= 0; i--) begin
                z          = z & (disp_val_d[(c*N_DIGITS + i)*4 +: 4] == 4'h0);
                zero_hi[i] = z;
            end
        end

        assign nib   = disp_val_d[(c*N_DIGITS + int'(dig_q))*4 +: 4];
        assign dpb   = disp_dp_d[c*N_DIGITS + int'(dig_q)];
        assign blank = disp_lz_d[c] && (dig_q != '0) && zero_hi[dig_q];
        assign ch_on[c] = lit && !(blink[c] && (bph_d == BLINK_OFF));

        seven_seg_decode u_dec (
            .nib_i   (nib),
            .dp_i    (dpb),
            .blank_i (blank),
            .seg_o   (seg_d[c*8 +: 8])
        );
    end

    always_comb begin
        an_d = '1;
        for (int c = 0; c < N_DISP; c++) begin
            if (ch_on[c]) begin
                an_d[c*N_DIGITS + int'(dig_q)] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            dig_q      <= '0;
            bright_q   <= '0;
            bcnt_q     <= '0;
            bph_q      <= BLINK_ON;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            disp_lz_q  <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            pend_lz_q  <= '0;
            pend_q     <= 1'b0;
            an_q       <= '1;
            seg_q      <= {N_DISP{SEG_BLANK}};
            fd_q       <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            dig_q      <= dig_d;
            bright_q   <= bright_d;
            bcnt_q     <= bcnt_d;
            bph_q      <= bph_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            disp_lz_q  <= disp_lz_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            pend_lz_q  <= pend_lz_d;
            pend_q     <= pend_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            fd_q       <= fd_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = fd_q;

endmodule
